// File: rtl/vram_pkg.sv
// Shared types and limits for the VRAM arbiter: FSM state encoding and wait-state maximum.
package vram_pkg;
   localparam int WAIT_MAX = 7;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      VACC  = 3'd1,
      CACC  = 3'd2,
      VDONE = 3'd3,
      CDONE = 3'd4
   } arb_state_t;
endpackage

// File: rtl/vram_wait_cnt.sv
// Access-length down-counter: loads WAIT while idle, counts down during an access,
// and flags the last access cycle when it reaches zero.
module vram_wait_cnt
   import vram_pkg::*;
#(
   parameter int WAIT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic run,
   output logic last
);
   localparam logic [2:0] WAIT_L = 3'((WAIT > WAIT_MAX) ? WAIT_MAX : WAIT);

   logic [2:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (load)
         cnt <= WAIT_L;
      else if (run && cnt != 3'd0)
         cnt <= cnt - 3'd1;
   end

   assign last = run && (cnt == 3'd0);
endmodule

// File: rtl/vram_arb.sv
// Two-port arbiter (video read port, CPU read/write port) onto one single-port memory.
// Build option VRAM_ARB_RR_EN: round-robin on ties instead of fixed video priority.
//
// state | meaning
// IDLE  | pick an eligible requester, latch its address/command
// VACC  | video access, mem_ce held for WAIT+1 cycles
// CACC  | CPU access, mem_ce held for WAIT+1 cycles
// VDONE | vram_complete pulse, VDI already updated
// CDONE | cpu_ready pulse, cpu_do already updated on reads
module vram_arb
   import vram_pkg::*;
#(
   parameter int WAIT = 1,
   parameter int AW   = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          vram_cs,
   input  logic [15:0]   VAD,
   output logic [7:0]    VDI,
   output logic          vram_complete,
   input  logic          cpu_cs,
   input  logic          cpu_rw,
   input  logic [15:0]   cpu_addr,
   input  logic [7:0]    cpu_di,
   output logic [7:0]    cpu_do,
   output logic          cpu_ready,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata,
   output logic          mem_ce,
   output logic          mem_we
);
   arb_state_t state, state_nxt;

   logic [15:0] addr_q;
   logic [7:0]  wdata_q;
   logic        wr_q;
   logic        guard_v, guard_c;
   logic        elig_v, elig_c, pick_v;
   logic        acc_last;

   // A requester that was just served stays blocked until it has been seen low.
   assign elig_v = vram_cs && !guard_v;
   assign elig_c = cpu_cs && !guard_c;

`ifdef VRAM_ARB_RR_EN
   logic last_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_c <= 1'b1;
      else if (state == VDONE)
         last_c <= 1'b0;
      else if (state == CDONE)
         last_c <= 1'b1;
   end

   assign pick_v = elig_v && (!elig_c || last_c);
`else
   assign pick_v = elig_v;
`endif

   vram_wait_cnt #(.WAIT(WAIT)) u_wait_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (state == IDLE),
      .run  (mem_ce),
      .last (acc_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pick_v)
               state_nxt = VACC;
            else if (elig_c)
               state_nxt = CACC;
         end
         VACC:    if (acc_last) state_nxt = VDONE;
         CACC:    if (acc_last) state_nxt = CDONE;
         VDONE:   state_nxt = IDLE;
         CDONE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mem_ce        = 1'b0;
      mem_we        = 1'b0;
      vram_complete = 1'b0;
      cpu_ready     = 1'b0;
      case (state)
         VACC:    mem_ce = 1'b1;
         CACC: begin
            mem_ce = 1'b1;
            mem_we = wr_q;
         end
         VDONE:   vram_complete = 1'b1;
         CDONE:   cpu_ready = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         VDI     <= 8'h00;
         cpu_do  <= 8'h00;
         guard_v <= 1'b0;
         guard_c <= 1'b0;
      end else begin
         if (state == IDLE) begin
            if (pick_v) begin
               addr_q <= VAD;
               wr_q   <= 1'b0;
            end else if (elig_c) begin
               addr_q  <= cpu_addr;
               wr_q    <= !cpu_rw;
               wdata_q <= cpu_di;
            end
         end
         if (acc_last && state == VACC)
            VDI <= mem_rdata;
         if (acc_last && state == CACC && !wr_q)
            cpu_do <= mem_rdata;
         if (state == VDONE)
            guard_v <= vram_cs;
         else if (!vram_cs)
            guard_v <= 1'b0;
         if (state == CDONE)
            guard_c <= cpu_cs;
         else if (!cpu_cs)
            guard_c <= 1'b0;
      end
   end

   assign mem_addr  = addr_q[AW-1:0];
   assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_vram_arb.sv
// Self-checking bench for vram_arb: phase-count reference model compared every cycle,
// plus directed scenarios with literal expectations. Honors VRAM_ARB_RR_EN.
module tb_vram_arb;
   localparam int WAIT = 1;
   localparam int DONE_PH = WAIT + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        vram_cs = 1'b0;
   logic [15:0] VAD = '0;
   logic [7:0]  VDI;
   logic        vram_complete;
   logic        cpu_cs = 1'b0;
   logic        cpu_rw = 1'b1;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_di = '0;
   logic [7:0]  cpu_do;
   logic        cpu_ready;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ce;
   logic        mem_we;

   int n_chk = 0;
   int n_fail = 0;

   vram_arb #(.WAIT(WAIT), .AW(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .vram_cs       (vram_cs),
      .VAD           (VAD),
      .VDI           (VDI),
      .vram_complete (vram_complete),
      .cpu_cs        (cpu_cs),
      .cpu_rw        (cpu_rw),
      .cpu_addr      (cpu_addr),
      .cpu_di        (cpu_di),
      .cpu_do        (cpu_do),
      .cpu_ready     (cpu_ready),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .mem_ce        (mem_ce),
      .mem_we        (mem_we)
   );

   always #5 clk = ~clk;

   // Memory: written bytes remembered, otherwise a fixed address hash (C123 holds A5).
   logic [7:0] wmem [0:65535];
   bit         wvalid [0:65535];

   always @(posedge clk)
      if (mem_we) begin
         wmem[mem_addr]   <= mem_wdata;
         wvalid[mem_addr] <= 1'b1;
      end

   function automatic logic [7:0] memval(input logic [15:0] a);
      if (wvalid[a]) return wmem[a];
      if (a == 16'hC123) return 8'hA5;
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   always_comb
      mem_rdata = wvalid[mem_addr] ? wmem[mem_addr] :
                  ((mem_addr == 16'hC123) ? 8'hA5 : (mem_addr[7:0] ^ mem_addr[15:8] ^ 8'h5A));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 = waiting, 1..WAIT+1 = memory busy, WAIT+2 = completion pulse.
   int          m_phase;
   bit          m_cpu, m_wr, g_v, g_c, m_lastc;
   logic [15:0] m_addr;
   logic [7:0]  m_wd, m_vdi, m_cdo;
   logic        m_ev, m_ec, m_vwin;

   assign m_ev = vram_cs && !g_v;
   assign m_ec = cpu_cs && !g_c;
`ifdef VRAM_ARB_RR_EN
   assign m_vwin = m_ev && (!m_ec || m_lastc);
`else
   assign m_vwin = m_ev;
`endif

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_phase <= 0;
         m_cpu   <= 1'b0;
         m_wr    <= 1'b0;
         m_addr  <= '0;
         m_wd    <= '0;
         m_vdi   <= 8'h00;
         m_cdo   <= 8'h00;
         g_v     <= 1'b0;
         g_c     <= 1'b0;
         m_lastc <= 1'b1;
      end else begin
         if (m_phase == 0) begin
            if (m_vwin) begin
               m_phase <= 1; m_cpu <= 1'b0; m_wr <= 1'b0; m_addr <= VAD;
            end else if (m_ec) begin
               m_phase <= 1; m_cpu <= 1'b1; m_wr <= !cpu_rw; m_addr <= cpu_addr; m_wd <= cpu_di;
            end
         end else if (m_phase < DONE_PH) begin
            if (m_phase == DONE_PH - 1) begin
               if (!m_cpu) m_vdi <= memval(m_addr);
               else if (!m_wr) m_cdo <= memval(m_addr);
            end
            m_phase <= m_phase + 1;
         end else begin
            m_phase <= 0;
            m_lastc <= m_cpu;
         end
         g_v <= (m_phase == DONE_PH && !m_cpu) ? vram_cs : (vram_cs && g_v);
         g_c <= (m_phase == DONE_PH &&  m_cpu) ? cpu_cs  : (cpu_cs && g_c);
      end
   end

   always @(negedge clk) begin
      chk("mem_ce", mem_ce, (m_phase >= 1 && m_phase < DONE_PH));
      chk("mem_we", mem_we, (m_phase >= 1 && m_phase < DONE_PH && m_cpu && m_wr));
      chk("vram_complete", vram_complete, (m_phase == DONE_PH && !m_cpu));
      chk("cpu_ready", cpu_ready, (m_phase == DONE_PH && m_cpu));
      chk("VDI", VDI, m_vdi);
      chk("cpu_do", cpu_do, m_cdo);
      if (m_phase >= 1 && m_phase < DONE_PH) chk("mem_addr", mem_addr, m_addr);
      if (m_phase >= 1 && m_phase < DONE_PH && m_cpu && m_wr) chk("mem_wdata", mem_wdata, m_wd);
      if (!rst) chk("mem_addr_rst", mem_addr, 16'h0000);
   end

   // One transaction on one port; reports latency, ce/we cycles, write bus, data at pulse,
   // and pulses of the same kind seen in the two cycles after the request is dropped.
   task automatic serve(input bit is_cpu, input bit rd, input logic [15:0] a, input logic [7:0] d,
                        output int lat, output int ce_n, output int we_n,
                        output logic [15:0] wa, output logic [7:0] wd, output logic [7:0] dat,
                        output int extra);
      bit done = 0;
      lat = 0; ce_n = 0; we_n = 0; wa = '0; wd = '0; dat = '0; extra = 0;
      @(negedge clk); #1;
      if (is_cpu) begin
         cpu_cs = 1'b1; cpu_rw = rd; cpu_addr = a; cpu_di = d;
      end else begin
         vram_cs = 1'b1; VAD = a;
      end
      for (int i = 1; i <= 20 && !done; i++) begin
         @(negedge clk);
         if (mem_ce) ce_n++;
         if (mem_we) begin we_n++; wa = mem_addr; wd = mem_wdata; end
         if (is_cpu ? cpu_ready : vram_complete) begin
            lat = i; dat = is_cpu ? cpu_do : VDI; done = 1;
         end
      end
      if (!done) chk("serve_timeout", 0, 1);
      #1;
      cpu_cs = 1'b0; vram_cs = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (is_cpu ? cpu_ready : vram_complete) extra++;
      end
   endtask

   int          lat, ce_n, we_n, extra, tv, tc, npulse;
   logic [15:0] wa;
   logic [7:0]  wd, dat, cdo_before;
   logic [3:0]  order, exp_order;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_VDI", VDI, 8'h00);
      chk("rst_cpu_do", cpu_do, 8'h00);
      chk("rst_mem_ce", mem_ce, 1'b0);
      chk("rst_mem_addr", mem_addr, 16'h0000);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);

      // Video read C123 -> A5
      serve(1'b0, 1'b1, 16'hC123, 8'h00, lat, ce_n, we_n, wa, wd, dat, extra);
      chk("v_latency", lat, 3);
      chk("v_ce_cycles", ce_n, 2);
      chk("v_VDI", dat, 8'hA5);
      chk("v_we_cycles", we_n, 0);

      // CPU read 1234 -> 34^12^5A = 7C
      serve(1'b1, 1'b1, 16'h1234, 8'h00, lat, ce_n, we_n, wa, wd, dat, extra);
      chk("c_rd_latency", lat, 3);
      chk("c_rd_data", dat, 8'h7C);

      // CPU write 3C to 0040
      cdo_before = cpu_do;
      serve(1'b1, 1'b0, 16'h0040, 8'h3C, lat, ce_n, we_n, wa, wd, dat, extra);
      chk("c_wr_we_cycles", we_n, 2);
      chk("c_wr_addr", wa, 16'h0040);
      chk("c_wr_data", wd, 8'h3C);
      chk("c_wr_extra_ready", extra, 0);
      chk("c_wr_cpu_do_kept", cpu_do, cdo_before);
      chk("c_wr_cpu_do_lit", cpu_do, 8'h7C);

      serve(1'b1, 1'b1, 16'h0040, 8'h00, lat, ce_n, we_n, wa, wd, dat, extra);
      chk("c_readback", dat, 8'h3C);

      // Simultaneous requests: video first, CPU four cycles later
      @(negedge clk); #1;
      vram_cs = 1'b1; VAD = 16'h0100; cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0200;
      tv = 0; tc = 0;
      for (int i = 1; i <= 30 && (tv == 0 || tc == 0); i++) begin
         @(negedge clk);
         if (vram_complete) begin tv = i; #1 vram_cs = 1'b0; end
         if (cpu_ready) begin tc = i; #1 cpu_cs = 1'b0; end
      end
      chk("sim_v_latency", tv, 3);
      chk("sim_c_after_v", tc - tv, 4);
      repeat (3) @(negedge clk);

      // Video held high after completion: exactly one pulse
      @(negedge clk); #1;
      vram_cs = 1'b1; VAD = 16'h0777;
      npulse = 0;
      tv = 0;
      for (int i = 1; i <= 20 && tv == 0; i++) begin
         @(negedge clk);
         if (vram_complete) begin npulse++; tv = i; end
      end
      ce_n = 0;
      repeat (5) begin
         @(negedge clk);
         if (vram_complete) npulse++;
         if (mem_ce) ce_n++;
      end
      chk("hold_pulses", npulse, 1);
      chk("hold_no_reaccess", ce_n, 0);
      #1 vram_cs = 1'b0;
      repeat (3) @(negedge clk);

      // Both requesters re-raise right after each completion
      @(negedge clk); #1;
      vram_cs = 1'b1; VAD = 16'h0A0A; cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0B0B;
      order = '0; npulse = 0;
      for (int i = 1; i <= 60 && npulse < 4; i++) begin
         @(negedge clk);
         tv = vram_complete; tc = cpu_ready;
         if (tv != 0 || tc != 0) begin order = {order[2:0], tc[0]}; npulse++; end
         #1;
         vram_cs = (tv == 0); cpu_cs = (tc == 0);
      end
`ifdef VRAM_ARB_RR_EN
      exp_order = 4'b0101;
`else
      exp_order = 4'b0000;
`endif
      chk("alt_count", npulse, 4);
      chk("alt_order", order, exp_order);
      vram_cs = 1'b0; cpu_cs = 1'b0;
      repeat (8) @(negedge clk);

      // Reset in second VACC cycle abandons the access
      @(negedge clk); #1;
      vram_cs = 1'b1; VAD = 16'hC123;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_ce", mem_ce, 1'b1);
      #1 rst = 1'b0;
      #1 chk("rst_ce_now", mem_ce, 1'b0);
      vram_cs = 1'b0;
      npulse = 0;
      repeat (3) begin
         @(negedge clk);
         if (vram_complete) npulse++;
      end
      #1 rst = 1'b1;
      ce_n = 0;
      repeat (3) begin
         @(negedge clk);
         if (vram_complete) npulse++;
         if (mem_ce) ce_n++;
      end
      chk("rst_no_pulse", npulse, 0);
      chk("rst_idle_ce", ce_n, 0);
      chk("rst_VDI_clr", VDI, 8'h00);
      serve(1'b0, 1'b1, 16'hC123, 8'h00, lat, ce_n, we_n, wa, wd, dat, extra);
      chk("post_rst_latency", lat, 3);
      chk("post_rst_VDI", dat, 8'hA5);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
